// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture
// -----------------
// Receive side of a multiplexed 4-digit common-anode 7-segment bus. It
// watches the digit enables and segment lines and recovers the hex value
// currently shown on each digit. Scan transitions are filtered by requiring
// the synchronized bus to hold still for a number of cycles. Each stable
// pattern is then decoded back to a nibble, and blank or unrecognised
// patterns are flagged.
//
// Parameters
//   STABLE_CYCLES : consecutive identical synchronized samples needed before
//                   a capture (2..255).
//
// Ports
//   clk         : system clock, rising edge
//   rst         : asynchronous, active-high reset
//   AN[3:0]     : digit enables, active-low, bit i selects digit i
//   a_to_g[6:0] : segment lines, active-low, a_to_g[6]=a .. a_to_g[0]=g
//   digits[15:0]: decoded value of digit i at [4i+3:4i]
//   blank[3:0]  : last capture of digit i had all segments off
//   bad[3:0]    : last capture of digit i was not a recognised hex glyph
//   frame_valid : one-cycle pulse once all four digits have been captured
//                 since the previous pulse
module seg7_scan_capture #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  AN,
  input  logic [6:0]  a_to_g,
  output logic [15:0] digits,
  output logic [3:0]  blank,
  output logic [3:0]  bad,
  output logic        frame_valid
);

  localparam int            CW      = 8;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_CAP = CW'(STABLE_CYCLES - 1);

  // Bus layout inside the synchronizer: {AN, a_to_g}
  logic [10:0]   s1_reg;
  logic [10:0]   s2_reg;
  logic [10:0]   s2_prev_reg;

  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;
  logic          done_reg;
  logic          done_next;
  logic [3:0]    seen_reg;
  logic [3:0]    seen_next;
  logic          frame_valid_reg;
  logic          frame_valid_next;

  logic [3:0]    an_s;
  logic [6:0]    seg_s;
  logic [3:0]    sel;
  logic          legal;
  logic          changed;
  logic          capture;

  logic [3:0]    code;
  logic          known;
  logic          is_blank;

  // ---------------------------------------------------------------------
  // Two-flop synchronizer plus a copy of the previous synchronized sample
  // used for change detection.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_reg      <= '0;
      s2_reg      <= '0;
      s2_prev_reg <= '0;
    end else begin
      s1_reg      <= {AN, a_to_g};
      s2_reg      <= s1_reg;
      s2_prev_reg <= s2_reg;
    end
  end

  assign an_s    = s2_reg[10:7];
  assign seg_s   = s2_reg[6:0];
  assign sel     = ~an_s;
  // Exactly one digit enabled: sel is non-zero and a power of two.
  assign legal   = (sel != 4'b0000) && ((sel & (sel - 4'd1)) == 4'b0000);
  assign changed = (s2_reg != s2_prev_reg);

  // ---------------------------------------------------------------------
  // Stability counter and capture-done flag. The counter saturates so a
  // long dwell can never wrap around and cause a second capture; the done
  // flag additionally guarantees one capture per dwell.
  // ---------------------------------------------------------------------
  always_comb begin
    cnt_next  = cnt_reg;
    done_next = done_reg;
    capture   = 1'b0;
    if (!legal || changed) begin
      cnt_next  = '0;
      done_next = 1'b0;
    end else begin
      if (cnt_reg == CNT_MAX) begin
        cnt_next = CNT_MAX;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
      if ((cnt_next == CNT_CAP) && !done_reg) begin
        capture   = 1'b1;
        done_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg  <= '0;
      done_reg <= 1'b0;
    end else begin
      cnt_reg  <= cnt_next;
      done_reg <= done_next;
    end
  end

  // ---------------------------------------------------------------------
  // Segment pattern decode (active-low, a..g from MSB to LSB).
  // ---------------------------------------------------------------------
  always_comb begin
    code  = 4'h0;
    known = 1'b1;
    case (seg_s)
      7'b0000001: code = 4'h0;
      7'b1001111: code = 4'h1;
      7'b0010010: code = 4'h2;
      7'b0000110: code = 4'h3;
      7'b1001100: code = 4'h4;
      7'b0100100: code = 4'h5;
      7'b0100000: code = 4'h6;
      7'b0001111: code = 4'h7;
      7'b0000000: code = 4'h8;
      7'b0000100: code = 4'h9;
      7'b0001000: code = 4'hA;
      7'b1100000: code = 4'hB;
      7'b0110001: code = 4'hC;
      7'b1000010: code = 4'hD;
      7'b0110000: code = 4'hE;
      7'b0111000: code = 4'hF;
      default: begin
        code  = 4'h0;
        known = 1'b0;
      end
    endcase
  end

  assign is_blank = (seg_s == 7'b1111111);

  // ---------------------------------------------------------------------
  // Per-digit result registers. Only the digit selected by the captured
  // sample is written; the others keep their previous result.
  // ---------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit
      logic [3:0] value_reg;
      logic       blank_reg;
      logic       bad_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          value_reg <= 4'h0;
          blank_reg <= 1'b0;
          bad_reg   <= 1'b0;
        end else if (capture && sel[gi]) begin
          value_reg <= known ? code : 4'h0;
          blank_reg <= is_blank;
          bad_reg   <= !known && !is_blank;
        end
      end

      assign digits[4*gi +: 4] = value_reg;
      assign blank[gi]         = blank_reg;
      assign bad[gi]           = bad_reg;
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Frame tracking: accumulate which digits have been captured; the capture
  // that completes the set raises frame_valid for one cycle and restarts
  // the accumulation on the same edge.
  // ---------------------------------------------------------------------
  always_comb begin
    seen_next        = seen_reg;
    frame_valid_next = 1'b0;
    if (capture) begin
      seen_next = seen_reg | sel;
      if (seen_next == 4'b1111) begin
        frame_valid_next = 1'b1;
        seen_next        = 4'b0000;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seen_reg        <= 4'b0000;
      frame_valid_reg <= 1'b0;
    end else begin
      seen_reg        <= seen_next;
      frame_valid_reg <= frame_valid_next;
    end
  end

  assign frame_valid = frame_valid_reg;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Testbench for seg7_scan_capture: directed bus sequences, a run-length
// reference model compared every cycle, and literal expectations at the
// key points of each sequence.
module tb_seg7_scan_capture;

  localparam int S = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  AN = 4'b1111;
  logic [6:0]  a_to_g = 7'b1111111;
  logic [15:0] digits;
  logic [3:0]  blank;
  logic [3:0]  bad;
  logic        frame_valid;

  int checks   = 0;
  int passes   = 0;
  int fv_count = 0;
  int fv_base  = 0;

  always #5 clk = ~clk;

  seg7_scan_capture #(.STABLE_CYCLES(S)) dut (
    .clk         (clk),
    .rst         (rst),
    .AN          (AN),
    .a_to_g      (a_to_g),
    .digits      (digits),
    .blank       (blank),
    .bad         (bad),
    .frame_valid (frame_valid)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      passes++;
    end
  endtask

  // Glyph table: index = hex value, entry = active-low a..g pattern
  logic [6:0] pat [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                           7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                           7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                           7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  // ---------------------------------------------------------------------
  // Reference model: the bus value seen two edges late; a value is captured
  // on the edge where its run of identical legal samples reaches S.
  // ---------------------------------------------------------------------
  logic [10:0] m_d1 = '0, m_d2 = '0, m_last = '0, m_x = '0;
  int          m_run = 0;
  int          m_idx = 0;
  int          m_val = 0;
  bit          m_found = 0;
  logic [15:0] m_digits = '0;
  logic [3:0]  m_blank = '0, m_bad = '0, m_seen = '0;
  logic        m_fv = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_d1 = '0; m_d2 = '0; m_last = '0; m_run = 0;
      m_digits = '0; m_blank = '0; m_bad = '0; m_seen = '0; m_fv = 1'b0;
    end else begin
      m_x  = m_d2;
      m_d2 = m_d1;
      m_d1 = {AN, a_to_g};
      m_fv = 1'b0;
      if ($countones(~m_x[10:7]) != 1) m_run = 0;
      else if (m_x == m_last) m_run = (m_run < 1000) ? m_run + 1 : m_run;
      else m_run = 1;
      m_last = m_x;
      if (m_run == S) begin
        m_idx = 0;
        for (int k = 0; k < 4; k++) if (!m_x[7+k]) m_idx = k;
        m_found = 0;
        m_val   = 0;
        for (int k = 0; k < 16; k++) if (pat[k] == m_x[6:0]) begin m_found = 1; m_val = k; end
        m_digits[4*m_idx +: 4] = m_found ? m_val[3:0] : 4'h0;
        m_blank[m_idx] = (m_x[6:0] == 7'b1111111);
        m_bad[m_idx]   = !m_found && (m_x[6:0] != 7'b1111111);
        m_seen[m_idx]  = 1'b1;
        if (m_seen == 4'b1111) begin
          m_fv   = 1'b1;
          m_seen = 4'b0000;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("cyc_digits", {16'h0, digits}, {16'h0, m_digits});
      chk("cyc_blank", {28'h0, blank}, {28'h0, m_blank});
      chk("cyc_bad", {28'h0, bad}, {28'h0, m_bad});
      chk("cyc_frame_valid", {31'h0, frame_valid}, {31'h0, m_fv});
      if (frame_valid === 1'b1) fv_count++;
    end
  end

  // Drive a bus value and hold it for n edges; returns at posedge+2.
  task automatic hold(input logic [3:0] an, input logic [6:0] seg, input int n);
    AN = an;
    a_to_g = seg;
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    chk("rst_digits", {16'h0, digits}, 32'h0);
    chk("rst_blank", {28'h0, blank}, 32'h0);
    chk("rst_bad", {28'h0, bad}, 32'h0);
    chk("rst_fv", {31'h0, frame_valid}, 32'h0);

    // Single digit: value 2 on digit 0, visible at edge S+2
    $display("txn: digit0 shows 2");
    AN = 4'b1110;
    a_to_g = 7'b0010010;
    repeat (S + 1) @(posedge clk);
    #2 chk("t1_before_edge", {28'h0, digits[3:0]}, 32'h0);
    @(posedge clk);
    #2 chk("t1_capture_edge", {28'h0, digits[3:0]}, 32'h2);
    chk("t1_blank", {28'h0, blank}, 32'h0);
    chk("t1_bad", {28'h0, bad}, 32'h0);
    repeat (4) @(posedge clk);
    #2 chk("t1_no_frame", fv_count, 32'd0);

    // Full scan 1,3,A,F twice
    fv_base = fv_count;
    for (int r = 0; r < 2; r++) begin
      $display("txn: scan 1,3,A,F pass %0d", r);
      hold(4'b1110, 7'b1001111, 8);
      hold(4'b1101, 7'b0000110, 8);
      hold(4'b1011, 7'b0001000, 8);
      hold(4'b0111, 7'b0111000, 8);
      chk("t2_digits", {16'h0, digits}, 32'h0000FA31);
      chk("t2_frames", fv_count - fv_base, r + 1);
    end

    // Illegal enables: two digits low, then none
    $display("txn: illegal AN patterns");
    hold(4'b1100, 7'b0000001, 20);
    hold(4'b1111, 7'b0000001, 20);
    chk("t3_digits", {16'h0, digits}, 32'h0000FA31);
    chk("t3_frames", fv_count - fv_base, 32'd2);

    // Blank then bad pattern on digit 2
    $display("txn: digit2 blank");
    hold(4'b1011, 7'b1111111, 8);
    chk("t4_blank", {28'h0, blank}, 32'h4);
    chk("t4_blank_digits", {16'h0, digits}, 32'h0000F031);
    $display("txn: digit2 bad");
    hold(4'b1011, 7'b1010101, 8);
    chk("t4_bad", {28'h0, bad}, 32'h4);
    chk("t4_bad_blank", {28'h0, blank}, 32'h0);
    chk("t4_bad_digits", {16'h0, digits}, 32'h0000F031);

    // Glitch: 0 for 2 cycles, then 3 held
    $display("txn: digit0 glitch 0 then 3");
    hold(4'b1110, 7'b0000001, 2);
    a_to_g = 7'b0000110;
    repeat (S + 1) @(posedge clk);
    #2 chk("t5_no_glitch_capture", {28'h0, digits[3:0]}, 32'h1);
    @(posedge clk);
    #2 chk("t5_capture", {28'h0, digits[3:0]}, 32'h3);
    repeat (2) @(posedge clk);
    #2;

    // Async reset mid-frame after digits 0 and 1 captured
    $display("txn: digits 0,1 then async reset");
    hold(4'b1110, 7'b0100100, 8);
    hold(4'b1101, 7'b0001111, 8);
    chk("t6_pre_reset", {16'h0, digits}, 32'h0000F075);
    AN = 4'b1011;
    a_to_g = 7'b0000000;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("t6_rst_digits", {16'h0, digits}, 32'h0);
    chk("t6_rst_bad", {28'h0, bad}, 32'h0);
    chk("t6_rst_blank", {28'h0, blank}, 32'h0);
    chk("t6_rst_fv", {31'h0, frame_valid}, 32'h0);
    @(posedge clk);
    #2 rst = 1'b0;
    fv_base = fv_count;
    $display("txn: digits 2,3 after reset");
    hold(4'b1011, 7'b0000000, 8);
    hold(4'b0111, 7'b0000100, 8);
    chk("t6_partial_digits", {16'h0, digits}, 32'h00009800);
    chk("t6_partial_no_frame", fv_count - fv_base, 32'd0);
    $display("txn: digits 0,1 complete frame");
    hold(4'b1110, 7'b1100000, 8);
    hold(4'b1101, 7'b1000010, 8);
    chk("t6_full_digits", {16'h0, digits}, 32'h000098DB);
    chk("t6_full_frame", fv_count - fv_base, 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
